// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one shared full-add cell processes a WIDTH-bit add over WIDTH cycles.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVERFLOW_EN.
module serial_adder_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             c_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
`ifdef SERIAL_ADDER_OVERFLOW_EN
   ,
   output logic             overflow
`endif
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic             carry;
   logic [CNT_W-1:0] cnt;

   logic load_c;
   logic shift_c;
   logic last_c;
   logic ha0_s_c;
   logic ha0_c_c;
   logic fa_s_c;
   logic ha1_c_c;
   logic carry_nxt_c;

   // Shared 1-bit full adder: two half-add stages, carries merged by OR
   always_comb begin
      ha0_s_c     = a_sr[0] ^ b_sr[0];
      ha0_c_c     = a_sr[0] & b_sr[0];
      fa_s_c      = ha0_s_c ^ carry;
      ha1_c_c     = ha0_s_c & carry;
      carry_nxt_c = ha0_c_c | ha1_c_c;
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = ADD;
         ADD:     if (cnt == CNT_W'(WIDTH - 1)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      load_c  = 1'b0;
      shift_c = 1'b0;
      last_c  = 1'b0;
      case (state)
         IDLE: load_c = start;
         ADD: begin
            shift_c = 1'b1;
            last_c  = (cnt == CNT_W'(WIDTH - 1));
         end
         default: ;
      endcase
   end

   // Operand/result datapath; sum fills from the MSB end so bit i settles in sum[i]
   always_ff @(posedge clk) begin
      if (reset) begin
         a_sr  <= '0;
         b_sr  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         c_out <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= last_c;
         if (load_c) begin
            a_sr  <= A;
            b_sr  <= B;
            carry <= c_in;
            cnt   <= '0;
            sum   <= '0;
            c_out <= 1'b0;
            busy  <= 1'b1;
         end else if (shift_c) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            carry <= carry_nxt_c;
            sum   <= {fa_s_c, sum[WIDTH-1:1]};
            if (last_c) begin
               cnt   <= '0;
               c_out <= carry_nxt_c;
               busy  <= 1'b0;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
   end

`ifdef SERIAL_ADDER_OVERFLOW_EN
   // Signed overflow: carry into the MSB differs from carry out of it
   always_ff @(posedge clk) begin
      if (reset)       overflow <= 1'b0;
      else if (load_c) overflow <= 1'b0;
      else if (last_c) overflow <= carry ^ carry_nxt_c;
   end
`endif

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial add sequencer that owns and reuses one 1-bit full-add cell, built from two half-add stages plus an OR for carry.
- Performs a WIDTH-bit addition over WIDTH clock cycles using operand shift registers and a carry flop.
- Sits between a requester that issues start/operands and the shared single-bit adder datapath.
- Provides a start/busy/done handshake and holds results until the next operation.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32)

Ports:
clk  input  1  rising-edge clock; only clock in the block
reset  input  1  synchronous, active-high reset
start  input  1  request new addition; sampled only in IDLE
A  input  WIDTH  first operand, captured on accepted start
B  input  WIDTH  second operand, captured on accepted start
c_in  input  1  carry into bit 0, captured on accepted start
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse when sum/c_out become valid
sum  output  WIDTH  result, held stable until next accepted start
c_out  output  1  carry out of bit WIDTH-1, held with sum

Behaviour:
- Reset (synchronous, reset=1 at a rising edge): state=IDLE, busy=0, done=0, sum=0, c_out=0, carry flop=0, bit counter=0, operand shift registers=0. Reset has priority over every other event.
- States: IDLE, ADD, DONE. All outputs are registered.
- IDLE: if start=1 at edge k:
  - Load A and B into shift registers and c_in into the carry flop.
  - Clear the bit counter; clear sum and c_out.
  - Next state ADD; busy=1 from edge k.
  - If start=0, remain in IDLE.
- ADD, per edge:
  - Compute s = a0 ^ b0 ^ carry and carry_next = (a0 & b0) | (carry & (a0 ^ b0)), formed as two half-add stages.
  - Shift s into sum MSB-first-shift-right, so bit i lands in sum[i] after WIDTH shifts.
  - Shift the operand registers right by 1 and increment the counter.
  - On the edge that processes bit WIDTH-1 (edge k+WIDTH): c_out=carry_next, busy=0, done=1, next state DONE.
- DONE: lasts one cycle; done returns to 0 on the next edge; next state IDLE.
  - start is ignored in DONE.
  - Earliest re-accept is the edge after DONE, i.e. the edge where the state is IDLE.
- Latency: accepted start at edge k, then done high during the cycle following edge k+WIDTH, with sum/c_out valid at that same edge.
- Throughput: one operation per WIDTH+2 cycles.
- start while busy=1 or in DONE: ignored; operands are not re-captured and the in-flight operation is unaffected.
- A, B and c_in are don't-care after capture; changes mid-operation have no effect.
- Arithmetic is modulo 2^WIDTH with unsigned carry out. No internal width growth beyond the 1-bit carry.
- Reset mid-operation aborts: state=IDLE, busy=0, done=0, sum=0, c_out=0 at that edge. No done pulse is produced for the aborted operation.
- Counter width: clog2(WIDTH)+1 bits. Counter wraps to 0 on leaving ADD.

Optional Feature:
- Macro SERIAL_ADDER_OVERFLOW_EN.
- Defined: extra output port overflow (1 bit).
  - Reset value 0; cleared on accepted start.
  - Set at edge k+WIDTH to carry into bit WIDTH-1 XOR carry out of bit WIDTH-1 (two's-complement signed overflow).
  - Held with sum.
- Undefined: no overflow port and no associated logic. All other behaviour is identical.

Test Plan:
- WIDTH=8, reset 2 cycles, then A=0x0F, B=0x01, c_in=0, start 1 cycle -> busy=1 for 8 cycles; done pulses exactly 1 cycle at edge k+8; sum=0x10, c_out=0; sum held until next start.
- A=0xFF, B=0x01, c_in=0 -> sum=0x00, c_out=1. A=0x00, B=0x00, c_in=1 -> sum=0x01, c_out=0.
- A=0x12, B=0x34 accepted; pulse start with A=0xFF, B=0xFF at cycles k+3 and during DONE -> both ignored; result sum=0x46, c_out=0; single done pulse.
- A=0xAA, B=0x55 started; reset asserted at edge k+4 -> busy=0, done=0, sum=0x00, c_out=0 immediately; no done pulse follows; next start A=0x01, B=0x02 -> sum=0x03.
- With SERIAL_ADDER_OVERFLOW_EN: A=0x7F, B=0x01 -> sum=0x80, c_out=0, overflow=1; A=0xFF, B=0x01 -> sum=0x00, c_out=1, overflow=0.
- Random A, B, c_in, 500 back-to-back ops with start held high -> each result equals (A+B+c_in) mod 256 with matching carry; ops start every 10 cycles.
